rf_burst_reader: RTL
====================

Name: rf_burst_reader

Overview:
Read-side master for the on-chip register file: streams a contiguous burst of words out of the register-file array onto a valid/ready stream. Typical consumers are the pixel and weight feeders of the recognizer datapath. Drives the register file's clock-synchronous read port (address, en_read, en_write) and absorbs its 1-cycle read latency. Absorbs consumer back-pressure in a 2-entry output buffer. Sustains 1 word/cycle when the consumer is always ready.

Parameters:
DATA_WIDTH, 24, word width; must match the register file.
ADDR_DEPTH, 12, register-file address width (2**ADDR_DEPTH words).
LEN_WIDTH, 13, burst-length width (allows a burst of 2**ADDR_DEPTH words).

Ports:
clock  in  1  system clock; all state updates on the rising edge.
resetN  in  1  asynchronous active-low reset.
start  in  1  burst request; sampled only in IDLE.
base_addr  in  ADDR_DEPTH  first word address; latched on accepted start.
length  in  LEN_WIDTH  number of words; latched on accepted start.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  1-cycle completion pulse.
rf_address  out  ADDR_DEPTH  to register-file address.
rf_en_read  out  1  to register-file en_read.
rf_en_write  out  1  to register-file en_write; constant 0.
rf_data_in  in  DATA_WIDTH  from register-file data_out.
out_data  out  DATA_WIDTH  stream data (buffer head).
out_valid  out  1  stream valid.
out_ready  in  1  stream ready from the consumer.

Behaviour:
- Interface decision: one clock, `clock`; reset `resetN` is asynchronous, active-low. Reset clears state to IDLE and all counters and buffer entries. Reset output values: busy=0, done=0, rf_en_read=0, rf_address=0, out_valid=0, out_data=0. A reset asserted mid-burst aborts it immediately; no done pulse is produced for the aborted burst.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE, start=1, length>0: latch base_addr and length; go to READ.
- IDLE, start=1, length=0: go to DONE; no register-file access is made.
- start is ignored in every state other than IDLE.
- READ: issue one read per cycle while issued<length and (occ+inflight-pop)<=1.
  - occ is buffer occupancy (0..2); inflight is a read issued in the previous cycle; pop = out_valid & out_ready.
  - An issued read asserts rf_en_read=1, with rf_address = base + issued, taken modulo 2**ADDR_DEPTH (address wraps past the top).
  - rf_en_read and rf_address are combinational from registered state; rf_en_read=0 whenever no read is issued.
  - Go to DRAIN when the last read is issued.
- Read timing: read issued in cycle k -> the register file samples it at edge k -> rf_data_in is valid during cycle k+1 -> captured into the buffer at edge k+1. rf_data_in is never sampled in any other cycle; its contents are undefined (possibly Z) when not requested.
- Buffer: 2-entry FIFO. Push and pop may occur in the same cycle. out_valid = (occ!=0). out_data is stable while out_valid=1 and out_ready=0. Words leave in address order. The credit rule above guarantees the buffer never overflows.
- DRAIN: go to DONE when inflight=0 and occ=0.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. A start arriving in that DONE cycle is ignored.
- Latency: start sampled at edge E0 -> first out_valid after edge E2. With out_ready held high, one word per cycle; a burst of N words raises done at edge E(N+2).

Optional Feature:
RD_CHECKSUM_EN: when defined, adds output port checksum[DATA_WIDTH-1:0].
- Cleared on an accepted start.
- Accumulates (modulo 2**DATA_WIDTH) every word popped from the stream.
- Holds its final value from the done cycle until the next accepted start.
- Reset value 0.
When not defined, the port and the accumulator are absent and behaviour is otherwise identical.

Test Plan:
- Preload addr 0..7 with 0x000010+i; start, base=2, length=4, out_ready=1 -> out_data 0x12,0x13,0x14,0x15 on 4 consecutive cycles; first valid 2 cycles after start; done 1 cycle after last pop.
- base=0xFFE, length=4 -> rf_address sequence 0xFFE,0xFFF,0x000,0x001; data returned in that order.
- length=8, out_ready toggling 1,0,0,1,... -> all 8 words delivered in order, none lost or duplicated; rf_en_read never issued when occ+inflight-pop>1; out_data stable while stalled.
- start with length=0 -> done pulses the next cycle; rf_en_read stays 0; out_valid stays 0.
- resetN low for 1 cycle during word 3 of a 6-word burst -> outputs return to reset values asynchronously; no done pulse; a new burst with start works normally.
- With RD_CHECKSUM_EN: burst of 0xFFFFFF,0x000002 -> checksum=0x000001 at done.

Source files
------------

// File: rtl/rf_burst_reader.sv
// Streams a contiguous burst of register-file words onto a valid/ready stream,
// absorbing the 1-cycle read latency and consumer back-pressure. Optional RD_CHECKSUM_EN adds a popped-word checksum.
module rf_burst_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_DEPTH = 12,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [ADDR_DEPTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_DEPTH-1:0] rf_address,
    output logic                  rf_en_read,
    output logic                  rf_en_write,
    input  logic [DATA_WIDTH-1:0] rf_data_in,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            state_dbg
`ifdef RD_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    // Stream handshake: a word transfers on any rising edge where out_valid and
    // out_ready are both high; out_valid never drops and out_data never changes
    // while the word is waiting for out_ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_DEPTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            occ_q;

    logic       accept;
    logic       issue;
    logic       push;
    logic       pop;
    logic       last_issue;
    logic [1:0] occ_next;
    logic [2:0] credit_sum;
    logic [2:0] credit_lim;

    assign accept = (state_q == IDLE) && start;
    assign push   = inflight_q;
    assign pop    = out_valid && out_ready;

    // Occupancy plus the read still in flight must leave room after this cycle's pop.
    assign credit_sum = {1'b0, occ_q} + {2'b00, inflight_q};
    assign credit_lim = 3'd1 + {2'b00, pop};
    assign issue      = (state_q == READ) && (issued_q < len_q) && (credit_sum <= credit_lim);
    assign last_issue = issue && ((issued_q + LEN_WIDTH'(1)) == len_q);

    always_comb begin
        occ_next = occ_q;
        if (push && !pop) begin
            occ_next = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_next = occ_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            // Leave on the edge that empties the buffer so done follows the last pop directly.
            DRAIN: begin
                if (!inflight_q && (occ_next == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (accept) begin
                base_q   <= base_addr;
                len_q    <= length;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + LEN_WIDTH'(1);
            end
        end
    end

    // Two-entry FIFO; rf_data_in is only captured in the cycle after a read was issued.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= rf_data_in;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_next;
        end
    end

`ifdef RD_CHECKSUM_EN
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + out_data;
        end
    end
`endif

    assign rf_en_read  = issue;
    assign rf_address  = issue ? (base_q + issued_q[ADDR_DEPTH-1:0]) : '0;
    assign rf_en_write = 1'b0;
    assign out_valid   = (occ_q != 2'd0);
    assign out_data    = buf_q[rd_ptr_q];
    assign busy        = (state_q == READ) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign state_dbg   = state_q;

endmodule
